// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: word layout and FSM encoding for the uart word channel.
// Shared by uart_tx_arbiter and the uart_demux decoder.
package uart_tx_arbiter_pkg;

  localparam int WORD_W = 16;
  localparam int TAG_W  = 4;
  localparam int PAY_W  = WORD_W - TAG_W;

  localparam int TAG_HI = WORD_W - 1;
  localparam int TAG_LO = PAY_W;
  localparam int PAY_HI = PAY_W - 1;
  localparam int PAY_LO = 0;

  localparam logic [TAG_W-1:0] CHK_TAG = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_CHK
  } arb_state_e;

  function automatic logic [TAG_W-1:0] word_tag(
    input logic [WORD_W-1:0] w
  );
    return w[TAG_HI:TAG_LO];
  endfunction

  function automatic logic [PAY_W-1:0] word_pay(
    input logic [WORD_W-1:0] w
  );
    return w[PAY_HI:PAY_LO];
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: producer request bus plus the 16-bit uart word channel.
// slave = arbiter side, master = producers/uart side.
interface uart_tx_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int PAYLOAD_W = 12
);

  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ*PAYLOAD_W-1:0] req_data;
  logic [N_REQ-1:0]           req_ready;
  logic [15:0]                out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic                       busy;

  modport master (
    output req_valid,
    output req_data,
    output out_ready,
    input  req_ready,
    input  out_data,
    input  out_valid,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  out_ready,
    output req_ready,
    output out_data,
    output out_valid,
    output busy
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_tx_arbiter_rr_pick: combinational cyclic first-set finder.
// Returns the first set bit of mask at or after start, wrapping at W.
module uart_tx_arbiter_rr_pick #(
  parameter int W  = 3,
  parameter int IW = 4
) (
  input  logic [W-1:0]  mask,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] idx,
  output logic          found
);

  // descending scan so the candidate nearest to start is written last
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = W - 1; k >= 0; k--) begin
      int i;
      i = (int'(start) + k) % W;
      if (mask[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: tags and serialises producer words onto the uart channel.
// Optional checksum words enabled by `define UART_ARB_CHECKSUM_EN.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int PAYLOAD_W  = 12,
`ifdef UART_ARB_CHECKSUM_EN
  parameter int CHK_PERIOD = 8,
`endif
  parameter int GAP_CYCLES = 16
) (
  input logic clk,
  input logic rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int TW = WORD_W - PAYLOAD_W;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [GW-1:0] GAP_LD   = GW'(GAP_CYCLES);
  localparam logic [TW-1:0] RR_FIRST = TW'(1);
  localparam logic [TW-1:0] RR_LAST  = TW'(N_REQ - 1);

  arb_state_e state_q, state_d;
  arb_state_e post_gap;

  logic [TW-1:0]        rr_q, rr_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [WORD_W-1:0]    word_q, word_d;

  logic [TW-1:0]        pick_start;
  logic [TW-1:0]        pick_idx;
  logic                 pick_found;
  logic [TW-1:0]        win;
  logic                 win_v;
  logic [PAYLOAD_W-1:0] win_pay;
  logic                 xfer;

  assign pick_start = rr_q - 1'b1;

  uart_tx_arbiter_rr_pick #(
    .W  (N_REQ - 1),
    .IW (TW)
  ) u_pick (
    .mask  (bus.req_valid[N_REQ-1:1]),
    .start (pick_start),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // requester 0 overrides the rotating pick
  always_comb begin
    win   = pick_idx + 1'b1;
    win_v = pick_found;
    if (bus.req_valid[0]) begin
      win   = '0;
      win_v = 1'b1;
    end
  end

  assign win_pay = bus.req_data[win*PAYLOAD_W +: PAYLOAD_W];
  assign xfer    = bus.out_valid & bus.out_ready;

`ifdef UART_ARB_CHECKSUM_EN
  localparam int CW = $clog2(CHK_PERIOD + 1);
  localparam logic [CW-1:0] CHK_N = CW'(CHK_PERIOD);

  logic [PAYLOAD_W-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 chk_due;

  // fold accepted data payloads; clear once the checksum word goes out
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (xfer && state_q == ST_SEND) begin
      acc_d = acc_q ^ word_q[PAYLOAD_W-1:0];
      cnt_d = cnt_q + 1'b1;
    end else if (xfer && state_q == ST_CHK) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  assign chk_due  = (cnt_d == CHK_N);
  assign post_gap = chk_due ? ST_CHK : ST_IDLE;

  // checksum accumulator and word counter
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
`else
  assign post_gap = ST_IDLE;
`endif

  // next state, rotation pointer, gap counter and output word
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gap_d   = gap_q;
    word_d  = word_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_v) begin
          state_d = ST_SEND;
          word_d  = {win, win_pay};
          if (win != '0) begin
            rr_d = (win == RR_LAST) ? RR_FIRST : win + 1'b1;
          end
        end
      end
      ST_SEND, ST_CHK: begin
        if (xfer) begin
          gap_d   = GAP_LD;
          state_d = (GAP_CYCLES == 0) ? post_gap : ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end
        if (gap_q <= GW'(1)) begin
          state_d = post_gap;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef UART_ARB_CHECKSUM_EN
    if (state_d == ST_CHK && state_q != ST_CHK) begin
      word_d = {TW'(CHK_TAG), acc_d};
    end
`endif
  end

  // state register and datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rr_q    <= RR_FIRST;
      gap_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gap_q   <= gap_d;
      word_q  <= word_d;
    end
  end

  // grant pulse and valid decode from the current state
  always_comb begin
    bus.req_ready = '0;
    bus.out_valid = 1'b0;
    if (state_q == ST_IDLE && win_v) begin
      bus.req_ready = N_REQ'(1) << win;
    end
    if (state_q == ST_SEND || state_q == ST_CHK) begin
      bus.out_valid = 1'b1;
    end
  end

  assign bus.out_data = word_q;
  assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter
// against a cycle-timed transaction model.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int PW = 12;
  localparam int G  = 16;
`ifdef UART_ARB_CHECKSUM_EN
  localparam int P  = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

  uart_tx_arbiter_if #(.N_REQ(N), .PAYLOAD_W(PW)) bif ();

  uart_tx_arbiter #(
    .N_REQ      (N),
    .PAYLOAD_W  (PW),
`ifdef UART_ARB_CHECKSUM_EN
    .CHK_PERIOD (P),
`endif
    .GAP_CYCLES (G)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // model: a word is pending from grant until accepted; after acceptance
  // the arbiter is blind for G cycles; grants follow priority + rotation
  int          m_cyc = 0;
  bit          m_pend;
  bit          m_chk;
  int          m_vfrom, m_nfree, m_upd, m_rr;
  logic [15:0] m_word, m_next, m_out;
`ifdef UART_ARB_CHECKSUM_EN
  int          m_wc;
  logic [PW-1:0] m_acc;
`endif
  logic [15:0] dut_log[$];
  logic [15:0] dw[$];

  task automatic m_reset();
    m_pend  = 1'b0;
    m_chk   = 1'b0;
    m_vfrom = 0;
    m_nfree = 0;
    m_upd   = -1;
    m_rr    = 1;
    m_word  = '0;
    m_next  = '0;
    m_out   = '0;
`ifdef UART_ARB_CHECKSUM_EN
    m_wc    = 0;
    m_acc   = '0;
`endif
  endtask

  task automatic m_step();
    logic [N-1:0] rv;
    logic [N-1:0] eg;
    int w;
    bit ev, eb;
    rv = bif.req_valid;
    eg = '0;
    w = -1;
    if (!m_pend && m_cyc >= m_nfree) begin
      if (rv[0]) w = 0;
      else begin
        for (int k = 0; k < N - 1; k++) begin
          int i;
          i = 1 + (m_rr - 1 + k) % (N - 1);
          if (w < 0 && rv[i]) w = i;
        end
      end
    end
    if (w >= 0) eg[w] = 1'b1;
    if (m_cyc == m_upd) m_out = m_next;
    ev = m_pend && (m_cyc >= m_vfrom);
    eb = ev || (m_cyc < m_nfree);
    check("req_ready", bif.req_ready, eg);
    check("out_valid", bif.out_valid, ev);
    check("out_data", bif.out_data, m_out);
    check("busy", bif.busy, eb);
    if (bif.out_valid && bif.out_ready) dut_log.push_back(bif.out_data);
    if (w >= 0) begin
      m_word  = {4'(w), bif.req_data[w*PW +: PW]};
      m_next  = m_word;
      m_upd   = m_cyc + 1;
      m_vfrom = m_cyc + 1;
      m_pend  = 1'b1;
      m_chk   = 1'b0;
      if (w != 0) m_rr = (w == N - 1) ? 1 : w + 1;
    end else if (ev && bif.out_ready) begin
      m_pend  = 1'b0;
      m_nfree = m_cyc + 1 + G;
`ifdef UART_ARB_CHECKSUM_EN
      if (!m_chk) begin
        m_acc = m_acc ^ word_pay(m_word);
        m_wc++;
        if (m_wc == P) begin
          m_word  = {CHK_TAG, m_acc};
          m_next  = m_word;
          m_upd   = m_nfree;
          m_vfrom = m_nfree;
          m_pend  = 1'b1;
          m_chk   = 1'b1;
        end
      end else begin
        m_acc = '0;
        m_wc  = 0;
        m_chk = 1'b0;
      end
`endif
    end
  endtask

  // compare process: every cycle, away from the active edge
  initial forever begin
    @(negedge clk);
    if (rst) m_reset();
    else m_step();
    m_cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_grant(int i, int limit, output int n);
    n = -1;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (bif.req_ready[i]) begin
        n = c;
        break;
      end
    end
    check("grant_wait", 32'(n >= 0), 1);
  endtask

  task automatic wait_log(int cnt, int limit);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      #1;
      if (dut_log.size() >= cnt) begin
        ok = 1'b1;
        break;
      end
    end
    check("log_wait", 32'(ok), 1);
  endtask

  task automatic collect(int base);
    dw.delete();
    for (int k = base; k < dut_log.size(); k++) begin
      if (word_tag(dut_log[k]) != CHK_TAG) dw.push_back(dut_log[k]);
    end
  endtask

  logic [15:0] exp_rr [6] = '{16'h1001, 16'h2002, 16'h3003,
                              16'h1001, 16'h2002, 16'h3003};
  logic [15:0] exp_pr [4] = '{16'h1001, 16'h00AB, 16'h2002, 16'h3003};

  initial begin
    int n, base;
    bit stable;
    logic [N-1:0] g;
    bif.req_valid = '0;
    bif.req_data  = '0;
    bif.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_out_valid", bif.out_valid, 0);
    check("rst_busy", bif.busy, 0);
    check("rst_out_data", bif.out_data, 0);
    check("rst_req_ready", bif.req_ready, 0);

    // single request and gap length
    tick();
    bif.req_data[2*PW +: PW] = 12'h2A7;
    bif.req_valid = 4'b0100;
    bif.out_ready = 1'b1;
    @(negedge clk);
    check("single_ready", bif.req_ready, 4'b0100);
    tick();
    bif.req_valid = '0;
    bif.req_data  = '0;
    @(negedge clk);
    check("single_valid", bif.out_valid, 1);
    check("single_data", bif.out_data, 16'h22A7);
    tick();
    bif.req_valid = 4'b0100;
    wait_grant(2, 40, n);
    check("gap_len", n, G);
    tick();
    bif.req_valid = '0;
    repeat (3) tick();

    // round robin over 1..3
    bif.req_valid = '0;
    do_reset();
    bif.req_data = {12'h003, 12'h002, 12'h001, 12'h000};
    bif.out_ready = 1'b1;
    base = dut_log.size();
    bif.req_valid = 4'b1110;
    wait_log(base + 9, 400);
    tick();
    bif.req_valid = '0;
    collect(base);
    check("rr_count_min", 32'(dw.size() >= 6), 1);
    for (int k = 0; k < 6; k++) begin
      if (k < dw.size()) check("rr_word", dw[k], exp_rr[k]);
    end

    // priority preempts and rotation resumes
    do_reset();
    bif.req_data = {12'h003, 12'h002, 12'h001, 12'h0AB};
    base = dut_log.size();
    bif.req_valid = 4'b1110;
    wait_log(base + 1, 60);
    tick();
    bif.req_valid[0] = 1'b1;
    wait_grant(0, 60, n);
    tick();
    bif.req_valid[0] = 1'b0;
    wait_log(base + 5, 300);
    tick();
    bif.req_valid = '0;
    collect(base);
    for (int k = 0; k < 4; k++) begin
      if (k < dw.size()) check("prio_word", dw[k], exp_pr[k]);
    end

    // backpressure
    do_reset();
    bif.out_ready = 1'b0;
    bif.req_data[1*PW +: PW] = 12'h155;
    bif.req_valid = 4'b0010;
    wait_grant(1, 10, n);
    tick();
    bif.req_data[3*PW +: PW] = 12'h777;
    bif.req_valid = 4'b1000;
    base = dut_log.size();
    stable = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!(bif.out_valid === 1'b1 && bif.out_data === 16'h1155 &&
            bif.req_ready === '0)) stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 1);
    check("bp_no_xfer", dut_log.size(), base);
    tick();
    bif.out_ready = 1'b1;
    repeat (5) tick();
    check("bp_one_xfer", dut_log.size(), base + 1);
    if (dut_log.size() > base) check("bp_word", dut_log[base], 16'h1155);
    wait_grant(3, 40, n);
    tick();
    bif.req_valid = '0;
    wait_log(base + 2, 40);
    if (dut_log.size() > base + 1) check("bp_next", dut_log[base+1], 16'h3777);

    // reset while a word is presented
    do_reset();
    bif.out_ready = 1'b0;
    bif.req_data[2*PW +: PW] = 12'h3C3;
    bif.req_valid = 4'b0100;
    wait_grant(2, 10, n);
    tick();
    bif.req_valid = '0;
    @(negedge clk);
    check("rs_presented", bif.out_valid, 1);
    base = dut_log.size();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bif.out_ready = 1'b1;
    @(negedge clk);
    check("rs_out_valid", bif.out_valid, 0);
    check("rs_busy", bif.busy, 0);
    check("rs_out_data", bif.out_data, 0);
    repeat (30) tick();
    check("rs_dropped", dut_log.size(), base);

`ifdef UART_ARB_CHECKSUM_EN
    // checksum word after P data words
    do_reset();
    bif.out_ready = 1'b1;
    base = dut_log.size();
    bif.req_data[1*PW +: PW] = 12'h0F0;
    bif.req_valid = 4'b0010;
    wait_grant(1, 10, n);
    tick();
    bif.req_data[2*PW +: PW] = 12'h00F;
    bif.req_valid = 4'b0100;
    wait_grant(2, 60, n);
    tick();
    bif.req_data[3*PW +: PW] = 12'h456;
    bif.req_valid = 4'b1000;
    wait_grant(3, 120, n);
    tick();
    bif.req_valid = '0;
    check("chk_before_grant", dut_log.size(), base + 3);
    if (dut_log.size() > base + 2) check("chk_word", dut_log[base+2], 16'hF0FF);
`endif

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g = bif.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (g[i]) bif.req_valid[i] = 1'b0;
        else if (!bif.req_valid[i]) begin
          if ($urandom_range(0, (i == 0) ? 40 : 5) == 0) begin
            bif.req_valid[i] = 1'b1;
            bif.req_data[i*PW +: PW] = PW'($urandom);
          end
        end else if ($urandom_range(0, 40) == 0) begin
          bif.req_valid[i] = 1'b0;
        end
      end
      bif.out_ready = ($urandom_range(0, 3) != 0);
    end
    bif.req_valid = '0;
    bif.out_ready = 1'b1;
    repeat (80) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
